irq_arbiter8: RTL and testbench

IRQ_ARBITER8 -- requirements
Module: irq_arbiter8

---
 rtl/irq_arbiter8_pkg.sv | 25 ++
 rtl/irq_arbiter8_prio_enc8.sv | 25 ++
 rtl/irq_arbiter8.sv | 120 ++++++++++++
 tb/tb_irq_arbiter8.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/irq_arbiter8_pkg.sv
// Shared types and constants for the 8-source interrupt arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irq_arbiter8_pkg;

  // Number of interrupt sources and the width of their binary index.
  localparam int NSRC = 8;
  localparam int IDXW = 3;

  // Two-state grant FSM: waiting for an eligible source, or holding a code
  // until the consumer acknowledges it.
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  // One-hot vector with only bit idx set; used to clear an acknowledged source.
  function automatic logic [NSRC-1:0] idx_to_onehot(input logic [IDXW-1:0] idx);
    logic [NSRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/irq_arbiter8_prio_enc8.sv
// Lowest-index-wins priority encoder over an 8-bit request vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none; any_o=0 means idx carries no meaning.
module prio_enc8
  import irq_arbiter8_pkg::*;
(
  input  logic [NSRC-1:0] vec,
  output logic [IDXW-1:0] idx,
  output logic            any_o
);

  // Scan from the lowest-priority bit upward so the lowest set index is the
  // last assignment and therefore wins.
  always_comb begin
    idx   = '0;
    any_o = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDXW'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter8.sv
// Captures 8 interrupt requests into a pending register and presents the lowest eligible index.
// Latency: req sampled at edge k -> pending after k -> valid_o after k+1 (FSM idle, source unmasked).
// Backpressure: a presented code is held until ack_i; at least one valid_o=0 cycle between grants.
module irq_arbiter8
  import irq_arbiter8_pkg::*;
#(
  parameter int EDGE_MODE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] req,
  input  logic [NSRC-1:0] mask,
  input  logic            ack_i,
  output logic            valid_o,
  output logic [IDXW-1:0] code_o,
  output logic [NSRC-1:0] pending_o
);

  state_t          state;
  state_t          next_state;
  logic [NSRC-1:0] req_d;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] captured;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] clr_vec;
  logic [IDXW-1:0] grant_idx;
  logic            grant_any;
  logic            load_code;

  // New pending events: rising edges in edge mode, raw level otherwise.
  // req_d resets to all-ones so a line already high when reset releases is
  // not mistaken for a fresh edge.
  assign captured = (EDGE_MODE != 0) ? (req & ~req_d) : req;

  // Mask only decides who may win; it never stops a bit from pending.
  assign eligible = pending & mask;

  prio_enc8 u_prio (
    .vec   (eligible),
    .idx   (grant_idx),
    .any_o (grant_any)
  );

  // Registered copy of req for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_d <= '1;
    end else begin
      req_d <= req;
    end
  end

  // Next-state logic: grant from IDLE, release and clear on ack in PRESENT.
  always_comb begin
    next_state = state;
    load_code  = 1'b0;
    clr_vec    = '0;
    unique case (state)
      ST_IDLE: begin
        // ack_i is deliberately ignored here.
        if (grant_any) begin
          next_state = ST_PRESENT;
          load_code  = 1'b1;
        end
      end
      ST_PRESENT: begin
        // code_o is frozen; mask or pending changes have no effect until ack.
        if (ack_i) begin
          next_state = ST_IDLE;
          clr_vec    = idx_to_onehot(code_o);
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Registered grant outputs; code_o keeps its last value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      code_o  <= '0;
    end else begin
      valid_o <= (next_state == ST_PRESENT);
      if (load_code) begin
        code_o <= grant_idx;
      end
    end
  end

  // Pending register: a set on the same edge as a clear leaves the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | captured;
    end
  end

  assign pending_o = pending;

  // A presented code must not move or vanish without an acknowledge.
  a_hold : assert property (@(posedge clk) disable iff (rst)
    (state == ST_PRESENT && !ack_i) |=> (valid_o && $stable(code_o)));

  // Every acknowledged grant is followed by at least one idle cycle.
  a_gap : assert property (@(posedge clk) disable iff (rst)
    (state == ST_PRESENT && ack_i) |=> !valid_o);

endmodule

// File: tb/tb_irq_arbiter8.sv
module tb_irq_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack_i;

  logic       valid_e, valid_l;
  logic [2:0] code_e, code_l;
  logic [7:0] pend_e, pend_l;

  int errors = 0;
  int checks = 0;

  // Reference state, index 1 = edge-mode instance, index 0 = level-mode instance.
  bit [7:0] m_pend [2];
  bit [7:0] m_reqd [2];
  bit       m_valid[2];
  bit [2:0] m_code [2];

  always #5 clk = ~clk;

  irq_arbiter8 #(.EDGE_MODE(1)) dut_e (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .ack_i(ack_i),
    .valid_o(valid_e), .code_o(code_e), .pending_o(pend_e)
  );

  irq_arbiter8 #(.EDGE_MODE(0)) dut_l (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .ack_i(ack_i),
    .valid_o(valid_l), .code_o(code_l), .pending_o(pend_l)
  );

  // Drive one cycle of inputs, advance the reference across the edge, and
  // return 1 time unit after the edge so outputs can be sampled.
  task automatic tick(input bit [7:0] r, input bit [7:0] mk, input bit a, input bit rs);
    req = r; mask = mk; ack_i = a; rst = rs;
    @(posedge clk);
    for (int md = 0; md < 2; md++) begin
      if (rs) begin
        m_pend[md] = 8'h00; m_valid[md] = 1'b0; m_code[md] = 3'd0; m_reqd[md] = 8'hFF;
      end else begin
        bit [7:0] newreq;
        bit [7:0] keep;
        bit [7:0] elig;
        newreq = (md == 1) ? (r & ~m_reqd[md]) : r;
        keep   = m_pend[md];
        if (m_valid[md]) begin
          if (a) begin
            keep[m_code[md]] = 1'b0;
            m_valid[md]      = 1'b0;
          end
        end else begin
          elig = m_pend[md] & mk;
          for (int i = 7; i >= 0; i--) begin
            if (elig[i]) begin
              m_code[md]  = 3'(i);
              m_valid[md] = 1'b1;
            end
          end
        end
        m_pend[md] = keep | newreq;
        m_reqd[md] = r;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    tick(8'h00, 8'hFF, 1'b0, 1'b1);
    checks++; if (valid_e !== 1'b0 || code_e !== 3'd0 || pend_e !== 8'h00) begin errors++; $display("FAIL reset_edge got valid=%0b code=%0d pend=%02h want 0/0/00", valid_e, code_e, pend_e); end
    checks++; if (valid_l !== 1'b0 || code_l !== 3'd0 || pend_l !== 8'h00) begin errors++; $display("FAIL reset_level got valid=%0b code=%0d pend=%02h want 0/0/00", valid_l, code_l, pend_l); end
    for (int c = 0; c < 10; c++) begin
      tick(8'h00, 8'hFF, 1'b0, 1'b0);
      checks++; if (valid_e !== 1'b0 || pend_e !== 8'h00) begin errors++; $display("FAIL quiet_cycle%0d got valid=%0b pend=%02h want 0/00", c, valid_e, pend_e); end
    end
  endtask

  task automatic test_two_sources;
    tick(8'h28, 8'hFF, 1'b0, 1'b0);
    checks++; if (valid_e !== 1'b0 || pend_e !== 8'h28) begin errors++; $display("FAIL two_src_capture got valid=%0b pend=%02h want 0/28", valid_e, pend_e); end
    tick(8'h00, 8'hFF, 1'b0, 1'b0);
    checks++; if (valid_e !== 1'b1 || code_e !== 3'd3) begin errors++; $display("FAIL two_src_first got valid=%0b code=%0d want 1/3", valid_e, code_e); end
    tick(8'h00, 8'hFF, 1'b1, 1'b0);
    checks++; if (valid_e !== 1'b0 || pend_e !== 8'h20) begin errors++; $display("FAIL two_src_gap got valid=%0b pend=%02h want 0/20", valid_e, pend_e); end
    tick(8'h00, 8'hFF, 1'b0, 1'b0);
    checks++; if (valid_e !== 1'b1 || code_e !== 3'd5) begin errors++; $display("FAIL two_src_second got valid=%0b code=%0d want 1/5", valid_e, code_e); end
    tick(8'h00, 8'hFF, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checks++; if (valid_e !== 1'b0 || pend_e !== 8'h00) begin errors++; $display("FAIL two_src_drained%0d got valid=%0b pend=%02h want 0/00", c, valid_e, pend_e); end
      tick(8'h00, 8'hFF, 1'b0, 1'b0);
    end
  endtask

  task automatic test_mask;
    tick(8'h05, 8'hFE, 1'b0, 1'b0);
    tick(8'h00, 8'hFE, 1'b0, 1'b0);
    checks++; if (valid_e !== 1'b1 || code_e !== 3'd2 || pend_e[0] !== 1'b1) begin errors++; $display("FAIL mask_skip got valid=%0b code=%0d pend=%02h want 1/2/bit0 set", valid_e, code_e, pend_e); end
    tick(8'h00, 8'hFF, 1'b1, 1'b0);
    checks++; if (valid_e !== 1'b0 || pend_e !== 8'h01) begin errors++; $display("FAIL mask_ack got valid=%0b pend=%02h want 0/01", valid_e, pend_e); end
    tick(8'h00, 8'hFF, 1'b0, 1'b0);
    checks++; if (valid_e !== 1'b1 || code_e !== 3'd0) begin errors++; $display("FAIL mask_unmask got valid=%0b code=%0d want 1/0", valid_e, code_e); end
    tick(8'h00, 8'hFF, 1'b1, 1'b0);
  endtask

  task automatic test_same_edge;
    tick(8'h10, 8'hFF, 1'b0, 1'b0);
    tick(8'h00, 8'hFF, 1'b0, 1'b0);
    tick(8'h00, 8'hFF, 1'b0, 1'b0);
    checks++; if (valid_e !== 1'b1 || code_e !== 3'd4) begin errors++; $display("FAIL same_edge_hold got valid=%0b code=%0d want 1/4", valid_e, code_e); end
    tick(8'h10, 8'hFF, 1'b1, 1'b0);
    checks++; if (valid_e !== 1'b0 || pend_e !== 8'h10) begin errors++; $display("FAIL same_edge_setwins got valid=%0b pend=%02h want 0/10", valid_e, pend_e); end
    tick(8'h00, 8'hFF, 1'b0, 1'b0);
    checks++; if (valid_e !== 1'b1 || code_e !== 3'd4) begin errors++; $display("FAIL same_edge_regrant got valid=%0b code=%0d want 1/4", valid_e, code_e); end
    tick(8'h00, 8'hFF, 1'b1, 1'b0);
    checks++; if (valid_e !== 1'b0 || pend_e !== 8'h00) begin errors++; $display("FAIL same_edge_clear got valid=%0b pend=%02h want 0/00", valid_e, pend_e); end
  endtask

  task automatic test_ack_idle_and_mask_present;
    tick(8'h40, 8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick(8'h00, 8'h00, 1'b1, 1'b0);
      checks++; if (valid_e !== 1'b0 || pend_e !== 8'h40) begin errors++; $display("FAIL idle_ack%0d got valid=%0b pend=%02h want 0/40", c, valid_e, pend_e); end
    end
    tick(8'h00, 8'hFF, 1'b0, 1'b0);
    tick(8'h00, 8'h00, 1'b0, 1'b0);
    checks++; if (valid_e !== 1'b1 || code_e !== 3'd6) begin errors++; $display("FAIL present_masked got valid=%0b code=%0d want 1/6", valid_e, code_e); end
    tick(8'h01, 8'hFF, 1'b0, 1'b0);
    checks++; if (valid_e !== 1'b1 || code_e !== 3'd6 || pend_e !== 8'h41) begin errors++; $display("FAIL present_newreq got valid=%0b code=%0d pend=%02h want 1/6/41", valid_e, code_e, pend_e); end
    tick(8'h00, 8'hFF, 1'b1, 1'b0);
    tick(8'h00, 8'hFF, 1'b0, 1'b0);
    checks++; if (valid_e !== 1'b1 || code_e !== 3'd0) begin errors++; $display("FAIL present_next got valid=%0b code=%0d want 1/0", valid_e, code_e); end
    tick(8'h00, 8'hFF, 1'b1, 1'b0);
  endtask

  task automatic test_reset_hold;
    tick(8'h02, 8'hFF, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick(8'h02, 8'hFF, 1'b0, 1'b0);
      checks++; if (valid_e !== 1'b0 || pend_e !== 8'h00) begin errors++; $display("FAIL held_through_reset%0d got valid=%0b pend=%02h want 0/00", c, valid_e, pend_e); end
    end
    tick(8'h00, 8'hFF, 1'b0, 1'b0);
    tick(8'h02, 8'hFF, 1'b0, 1'b0);
    tick(8'h02, 8'hFF, 1'b0, 1'b0);
    checks++; if (valid_e !== 1'b1 || code_e !== 3'd1) begin errors++; $display("FAIL reedge_grant got valid=%0b code=%0d want 1/1", valid_e, code_e); end
    tick(8'h00, 8'hFF, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid;
    tick(8'h81, 8'hFF, 1'b0, 1'b0);
    tick(8'h00, 8'hFF, 1'b0, 1'b0);
    checks++; if (valid_e !== 1'b1 || code_e !== 3'd0 || pend_e !== 8'h81) begin errors++; $display("FAIL mid_setup got valid=%0b code=%0d pend=%02h want 1/0/81", valid_e, code_e, pend_e); end
    tick(8'h00, 8'hFF, 1'b0, 1'b1);
    checks++; if (valid_e !== 1'b0 || pend_e !== 8'h00) begin errors++; $display("FAIL mid_reset got valid=%0b pend=%02h want 0/00", valid_e, pend_e); end
    tick(8'h00, 8'hFF, 1'b0, 1'b0);
    checks++; if (valid_e !== 1'b0 || pend_e !== 8'h00) begin errors++; $display("FAIL mid_after got valid=%0b pend=%02h want 0/00", valid_e, pend_e); end
  endtask

  task automatic test_level_mode;
    tick(8'h00, 8'hFF, 1'b0, 1'b1);
    tick(8'h08, 8'hFF, 1'b0, 1'b0);
    checks++; if (valid_l !== 1'b0 || pend_l !== 8'h08) begin errors++; $display("FAIL level_capture got valid=%0b pend=%02h want 0/08", valid_l, pend_l); end
    tick(8'h08, 8'hFF, 1'b0, 1'b0);
    checks++; if (valid_l !== 1'b1 || code_l !== 3'd3) begin errors++; $display("FAIL level_grant got valid=%0b code=%0d want 1/3", valid_l, code_l); end
    tick(8'h08, 8'hFF, 1'b1, 1'b0);
    checks++; if (valid_l !== 1'b0 || pend_l !== 8'h08) begin errors++; $display("FAIL level_setwins got valid=%0b pend=%02h want 0/08", valid_l, pend_l); end
    tick(8'h00, 8'hFF, 1'b0, 1'b0);
    tick(8'h00, 8'hFF, 1'b1, 1'b0);
    checks++; if (valid_l !== 1'b0 || pend_l !== 8'h00) begin errors++; $display("FAIL level_clear got valid=%0b pend=%02h want 0/00", valid_l, pend_l); end
  endtask

  task automatic test_random;
    bit [7:0] r, mk;
    bit       a, rs;
    tick(8'h00, 8'hFF, 1'b0, 1'b1);
    for (int c = 0; c < 400; c++) begin
      r  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      mk = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      a  = ($urandom_range(0, 1) == 1);
      rs = ($urandom_range(0, 79) == 0);
      tick(r, mk, a, rs);
      checks++; if (valid_e !== m_valid[1] || pend_e !== m_pend[1] || (m_valid[1] && code_e !== m_code[1])) begin errors++; $display("FAIL rand_edge c=%0d got valid=%0b code=%0d pend=%02h want %0b/%0d/%02h", c, valid_e, code_e, pend_e, m_valid[1], m_code[1], m_pend[1]); end
      checks++; if (valid_l !== m_valid[0] || pend_l !== m_pend[0] || (m_valid[0] && code_l !== m_code[0])) begin errors++; $display("FAIL rand_level c=%0d got valid=%0b code=%0d pend=%02h want %0b/%0d/%02h", c, valid_l, code_l, pend_l, m_valid[0], m_code[0], m_pend[0]); end
    end
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; mask = 8'hFF; ack_i = 1'b0;
    test_reset;
    test_two_sources;
    test_mask;
    test_same_edge;
    test_ack_idle_and_mask_present;
    test_reset_hold;
    test_reset_mid;
    test_level_mode;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
